alu_exec_unit: RTL and testbench

- Execute stage of the multi-cycle MIPS datapath: ALU control decoder, 32-bit ALU, ALUOut result register and branch-condition evaluator in one block.
- The controller supplies a 2-bit ALU control class; the instruction supplies the opcode, funct, shamt and rt fields.
- The datapath supplies the muxed ALU operands and the raw register-file read data used for branch compares.

---
 rtl/alu_exec_unit.sv | 170 +++++++++++++++++
 tb/tb_alu_exec_unit.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// Multi-cycle MIPS execute stage: ALU control decode, 32-bit ALU, ALUOut register and branch compare.
// Optional signed-overflow flag for add/sub/addi is built when ALU_OVERFLOW_EN is defined.
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic [4:0]       shamt,
  input  logic [4:0]       rt_field,
  input  logic [1:0]       alu_ctrl_op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  output logic [3:0]       alu_op,
  output logic [WIDTH-1:0] alu_result,
  output logic             zero,
  output logic [WIDTH-1:0] alu_result_reg,
`ifdef ALU_OVERFLOW_EN
  output logic             overflow,
`endif
  output logic             branch_taken
);

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_NOR  = 4'h5;
  localparam logic [3:0] OP_SLT  = 4'h6;
  localparam logic [3:0] OP_SLTU = 4'h7;
  localparam logic [3:0] OP_SLL  = 4'h8;
  localparam logic [3:0] OP_SRL  = 4'h9;
  localparam logic [3:0] OP_SRA  = 4'hA;
  localparam logic [3:0] OP_SLLV = 4'hB;
  localparam logic [3:0] OP_SRLV = 4'hC;
  localparam logic [3:0] OP_SRAV = 4'hD;
  localparam logic [3:0] OP_LUI  = 4'hE;

  logic [WIDTH-1:0] add_sum;
  logic [WIDTH-1:0] sub_diff;
  logic             lt_signed;
  logic             lt_unsigned;
  logic [WIDTH-1:0] alu_result_q;
  logic [WIDTH-1:0] alu_result_d;

  always_comb begin
    alu_op = OP_ADD;
    case (alu_ctrl_op)
      2'b00: alu_op = OP_ADD;
      2'b01: alu_op = OP_SUB;
      2'b10: begin
        case (funct)
          6'b100000, 6'b100001: alu_op = OP_ADD;
          6'b100010, 6'b100011: alu_op = OP_SUB;
          6'b100100:            alu_op = OP_AND;
          6'b100101:            alu_op = OP_OR;
          6'b100110:            alu_op = OP_XOR;
          6'b100111:            alu_op = OP_NOR;
          6'b101010:            alu_op = OP_SLT;
          6'b101011:            alu_op = OP_SLTU;
          6'b000000:            alu_op = OP_SLL;
          6'b000010:            alu_op = OP_SRL;
          6'b000011:            alu_op = OP_SRA;
          6'b000100:            alu_op = OP_SLLV;
          6'b000110:            alu_op = OP_SRLV;
          6'b000111:            alu_op = OP_SRAV;
          default:              alu_op = OP_ADD;
        endcase
      end
      default: begin
        case (op)
          6'b001000, 6'b001001: alu_op = OP_ADD;
          6'b001100:            alu_op = OP_AND;
          6'b001101:            alu_op = OP_OR;
          6'b001110:            alu_op = OP_XOR;
          6'b001010:            alu_op = OP_SLT;
          6'b001011:            alu_op = OP_SLTU;
          6'b001111:            alu_op = OP_LUI;
          default:              alu_op = OP_ADD;
        endcase
      end
    endcase
  end

  assign add_sum     = src_a + src_b;
  assign sub_diff    = src_a - src_b;
  assign lt_signed   = $signed(src_a) < $signed(src_b);
  assign lt_unsigned = src_a < src_b;

  // Code F is never produced by the decoder and falls through to zero.
  always_comb begin
    alu_result = '0;
    case (alu_op)
      OP_ADD:  alu_result = add_sum;
      OP_SUB:  alu_result = sub_diff;
      OP_AND:  alu_result = src_a & src_b;
      OP_OR:   alu_result = src_a | src_b;
      OP_XOR:  alu_result = src_a ^ src_b;
      OP_NOR:  alu_result = ~(src_a | src_b);
      OP_SLT:  alu_result = {{(WIDTH-1){1'b0}}, lt_signed};
      OP_SLTU: alu_result = {{(WIDTH-1){1'b0}}, lt_unsigned};
      OP_SLL:  alu_result = src_b << shamt;
      OP_SRL:  alu_result = src_b >> shamt;
      OP_SRA:  alu_result = $signed(src_b) >>> shamt;
      OP_SLLV: alu_result = src_b << src_a[4:0];
      OP_SRLV: alu_result = src_b >> src_a[4:0];
      OP_SRAV: alu_result = $signed(src_b) >>> src_a[4:0];
      OP_LUI:  alu_result = {src_b[15:0], {(WIDTH-16){1'b0}}};
      default: alu_result = '0;
    endcase
  end

  assign zero = (alu_result == '0);

  assign alu_result_d = alu_result;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_result_q <= '0;
    end else begin
      alu_result_q <= alu_result_d;
    end
  end

  assign alu_result_reg = alu_result_q;

`ifdef ALU_OVERFLOW_EN
  logic ovf_add;
  logic ovf_sub;
  logic is_add_trap;
  logic is_sub_trap;

  // Only the trapping forms (add, sub, addi) report overflow.
  assign ovf_add     = (src_a[WIDTH-1] == src_b[WIDTH-1]) && (add_sum[WIDTH-1] != src_a[WIDTH-1]);
  assign ovf_sub     = (src_a[WIDTH-1] != src_b[WIDTH-1]) && (sub_diff[WIDTH-1] != src_a[WIDTH-1]);
  assign is_add_trap = ((alu_ctrl_op == 2'b10) && (funct == 6'b100000)) ||
                       ((alu_ctrl_op == 2'b11) && (op == 6'b001000));
  assign is_sub_trap = (alu_ctrl_op == 2'b10) && (funct == 6'b100010);
  assign overflow    = (is_add_trap && ovf_add) || (is_sub_trap && ovf_sub);
`endif

  logic rs_neg;
  logic rs_zero;

  assign rs_neg  = rs_data[WIDTH-1];
  assign rs_zero = (rs_data == '0);

  always_comb begin
    branch_taken = 1'b0;
    case (op)
      6'b000100: branch_taken = (rs_data == rt_data);
      6'b000101: branch_taken = (rs_data != rt_data);
      6'b000110: branch_taken = rs_neg | rs_zero;
      6'b000111: branch_taken = !rs_neg && !rs_zero;
      6'b000001: begin
        if (rt_field == 5'b00000) begin
          branch_taken = rs_neg;
        end else if (rt_field == 5'b00001) begin
          branch_taken = !rs_neg;
        end
      end
      default: branch_taken = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: vector tables, reset sequence and randomized model compare.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  op;
  logic [5:0]  funct;
  logic [4:0]  shamt;
  logic [4:0]  rt_field;
  logic [1:0]  alu_ctrl_op;
  logic [31:0] src_a, src_b, rs_data, rt_data;
  logic [3:0]  alu_op;
  logic [31:0] alu_result, alu_result_reg;
  logic        zero, branch_taken;
`ifdef ALU_OVERFLOW_EN
  logic        overflow;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_exec_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst_n), .op(op), .funct(funct), .shamt(shamt), .rt_field(rt_field),
    .alu_ctrl_op(alu_ctrl_op), .src_a(src_a), .src_b(src_b), .rs_data(rs_data), .rt_data(rt_data),
    .alu_op(alu_op), .alu_result(alu_result), .zero(zero), .alu_result_reg(alu_result_reg),
`ifdef ALU_OVERFLOW_EN
    .overflow(overflow),
`endif
    .branch_taken(branch_taken)
  );

  typedef struct {
    logic [1:0]  ctrl;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic [4:0]  shamt;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_res;
    logic [3:0]  exp_op;
  } alu_vec_t;

  typedef struct {
    logic [5:0]  op;
    logic [4:0]  rtf;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        exp_br;
  } br_vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference semantics straight from the instruction definitions.
  function automatic logic [31:0] ref_alu(input logic [1:0] c, input logic [5:0] o, input logic [5:0] f,
                                          input logic [4:0] sa, input logic [31:0] a, input logic [31:0] b);
    int signed sb;
    sb = b;
    case (c)
      2'd0: return a + b;
      2'd1: return a - b;
      2'd2: begin
        case (f)
          6'd32, 6'd33: return a + b;
          6'd34, 6'd35: return a - b;
          6'd36: return a & b;
          6'd37: return a | b;
          6'd38: return a ^ b;
          6'd39: return ~(a | b);
          6'd42: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
          6'd43: return (a < b) ? 32'd1 : 32'd0;
          6'd0:  return b << sa;
          6'd2:  return b >> sa;
          6'd3:  return sb >>> sa;
          6'd4:  return b << a[4:0];
          6'd6:  return b >> a[4:0];
          6'd7:  return sb >>> a[4:0];
          default: return a + b;
        endcase
      end
      default: begin
        case (o)
          6'd8, 6'd9: return a + b;
          6'd12: return a & b;
          6'd13: return a | b;
          6'd14: return a ^ b;
          6'd10: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
          6'd11: return (a < b) ? 32'd1 : 32'd0;
          6'd15: return b * 32'd65536;
          default: return a + b;
        endcase
      end
    endcase
  endfunction

  function automatic logic ref_branch(input logic [5:0] o, input logic [4:0] rtf,
                                      input logic [31:0] rs, input logic [31:0] rt);
    int signed s;
    s = rs;
    case (o)
      6'd4: return rs == rt;
      6'd5: return rs != rt;
      6'd6: return s <= 0;
      6'd7: return s > 0;
      6'd1: return (rtf == 5'd0) ? (s < 0) : (rtf == 5'd1) ? (s >= 0) : 1'b0;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic ref_ovf(input logic [1:0] c, input logic [5:0] o, input logic [5:0] f,
                                   input logic [31:0] a, input logic [31:0] b);
    longint r;
    if ((c == 2'd2 && f == 6'd32) || (c == 2'd3 && o == 6'd8))
      r = longint'(int'(a)) + longint'(int'(b));
    else if (c == 2'd2 && f == 6'd34)
      r = longint'(int'(a)) - longint'(int'(b));
    else
      return 1'b0;
    return (r > 64'sd2147483647) || (r < -64'sd2147483648);
  endfunction

  // Applies ALU inputs, checks combinational outputs, then ALUOut after the next edge.
  task automatic run_alu(input string nm, input logic [1:0] c, input logic [5:0] o, input logic [5:0] f,
                         input logic [4:0] sa, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp);
    alu_ctrl_op = c; op = o; funct = f; shamt = sa; src_a = a; src_b = b;
    #1;
    $display("%s ctrl=%0d op=%b funct=%b a=%h b=%h res=%h", nm, c, o, f, a, b, alu_result);
    chk({nm, " result"}, alu_result, exp);
    chk({nm, " zero"}, {31'd0, zero}, {31'd0, exp == 32'd0});
`ifdef ALU_OVERFLOW_EN
    chk({nm, " overflow"}, {31'd0, overflow}, {31'd0, ref_ovf(c, o, f, a, b)});
`endif
    @(posedge clk); #1;
    chk({nm, " aluout"}, alu_result_reg, exp);
  endtask

  alu_vec_t av[$];
  br_vec_t  bv[$];

  initial begin
    av = '{
      '{2'd2, 6'd0, 6'b101010, 5'd0, 32'hFFFFFFFF, 32'h1, 32'h1, 4'h6},
      '{2'd2, 6'd0, 6'b101011, 5'd0, 32'hFFFFFFFF, 32'h1, 32'h0, 4'h7},
      '{2'd2, 6'd0, 6'b000011, 5'd4, 32'h0, 32'h80000000, 32'hF8000000, 4'hA},
      '{2'd2, 6'd0, 6'b000110, 5'd0, 32'h8, 32'h100, 32'h1, 4'hC},
      '{2'd3, 6'b001111, 6'd0, 5'd0, 32'h0, 32'h0000ABCD, 32'hABCD0000, 4'hE},
      '{2'd3, 6'b001101, 6'd0, 5'd0, 32'hF0, 32'h0F, 32'hFF, 4'h3},
      '{2'd0, 6'd0, 6'd0, 5'd0, 32'h5, 32'h7, 32'hC, 4'h0},
      '{2'd1, 6'd0, 6'd0, 5'd0, 32'h5, 32'h7, 32'hFFFFFFFE, 4'h1},
      '{2'd2, 6'd0, 6'b100111, 5'd0, 32'h0, 32'h0, 32'hFFFFFFFF, 4'h5},
      '{2'd2, 6'd0, 6'b111111, 5'd0, 32'h1, 32'h2, 32'h3, 4'h0},
      '{2'd3, 6'b000100, 6'd0, 5'd0, 32'h1, 32'h2, 32'h3, 4'h0},
      '{2'd2, 6'd0, 6'b000000, 5'd31, 32'h0, 32'h1, 32'h80000000, 4'h8},
      '{2'd2, 6'd0, 6'b000111, 5'd0, 32'h21, 32'h80000000, 32'hC0000000, 4'hD},
      '{2'd2, 6'd0, 6'b000010, 5'd4, 32'h0, 32'h80000000, 32'h08000000, 4'h9},
      '{2'd2, 6'd0, 6'b000100, 5'd0, 32'h3, 32'h1, 32'h8, 4'hB},
      '{2'd3, 6'b001010, 6'd0, 5'd0, 32'hFFFFFFFF, 32'h0, 32'h1, 4'h6},
      '{2'd3, 6'b001011, 6'd0, 5'd0, 32'hFFFFFFFF, 32'h0, 32'h0, 4'h7},
      '{2'd2, 6'd0, 6'b100110, 5'd0, 32'hF0, 32'hFF, 32'h0F, 4'h4},
      '{2'd2, 6'd0, 6'b100100, 5'd0, 32'hF0, 32'h3C, 32'h30, 4'h2},
      '{2'd2, 6'd0, 6'b100011, 5'd0, 32'h0, 32'h1, 32'hFFFFFFFF, 4'h1}
    };
    bv = '{
      '{6'b000100, 5'd0, 32'd3, 32'd3, 1'b1},
      '{6'b000101, 5'd0, 32'd3, 32'd3, 1'b0},
      '{6'b000110, 5'd0, 32'd0, 32'd9, 1'b1},
      '{6'b000111, 5'd0, 32'h80000000, 32'd0, 1'b0},
      '{6'b000001, 5'd1, 32'd0, 32'd0, 1'b1},
      '{6'b000001, 5'd2, 32'd0, 32'd0, 1'b0},
      '{6'b000001, 5'd0, 32'hFFFFFFFF, 32'd0, 1'b1},
      '{6'b000111, 5'd0, 32'd1, 32'd0, 1'b1},
      '{6'b000110, 5'd0, 32'd1, 32'd0, 1'b0},
      '{6'b000101, 5'd0, 32'd3, 32'd4, 1'b1},
      '{6'b000000, 5'd0, 32'd5, 32'd5, 1'b0}
    };

    op = '0; funct = '0; shamt = '0; rt_field = '0; alu_ctrl_op = '0;
    src_a = '0; src_b = '0; rs_data = '0; rt_data = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("reset clears aluout", alu_result_reg, 32'h0);
    src_a = 32'h55;
    repeat (2) @(posedge clk);
    #1;
    chk("reset holds aluout", alu_result_reg, 32'h0);
    rst_n = 1'b1;

    // Async clear mid-run, then first capture after release.
    run_alu("seq load", 2'd0, 6'd0, 6'd0, 5'd0, 32'h1234, 32'h0, 32'h1234);
    #2 rst_n = 1'b0;
    #1;
    $display("seq async reset aluout=%h", alu_result_reg);
    chk("async reset no edge", alu_result_reg, 32'h0);
    rst_n = 1'b1;
    run_alu("seq first capture", 2'd0, 6'd0, 6'd0, 5'd0, 32'd5, 32'd7, 32'd12);

    foreach (av[i]) begin
      run_alu($sformatf("vec%0d", i), av[i].ctrl, av[i].op, av[i].funct, av[i].shamt,
              av[i].a, av[i].b, av[i].exp_res);
      chk($sformatf("vec%0d alu_op", i), {28'd0, alu_op}, {28'd0, av[i].exp_op});
    end

    alu_ctrl_op = 2'd2; funct = 6'd0;
    foreach (bv[i]) begin
      op = bv[i].op; rt_field = bv[i].rtf; rs_data = bv[i].rs; rt_data = bv[i].rt;
      #1;
      $display("br%0d op=%b rtf=%0d rs=%h rt=%h taken=%b", i, bv[i].op, bv[i].rtf, bv[i].rs, bv[i].rt, branch_taken);
      chk($sformatf("br%0d taken", i), {31'd0, branch_taken}, {31'd0, bv[i].exp_br});
    end

`ifdef ALU_OVERFLOW_EN
    run_alu("ovf add", 2'd2, 6'd0, 6'b100000, 5'd0, 32'h7FFFFFFF, 32'h1, 32'h80000000);
    chk("ovf add flag", {31'd0, overflow}, 32'd1);
    run_alu("ovf addu", 2'd2, 6'd0, 6'b100001, 5'd0, 32'h7FFFFFFF, 32'h1, 32'h80000000);
    chk("ovf addu flag", {31'd0, overflow}, 32'd0);
    run_alu("ovf sub", 2'd2, 6'd0, 6'b100010, 5'd0, 32'h80000000, 32'h1, 32'h7FFFFFFF);
    chk("ovf sub flag", {31'd0, overflow}, 32'd1);
    run_alu("ovf addi", 2'd3, 6'b001000, 6'd0, 5'd0, 32'h80000000, 32'hFFFFFFFF, 32'h7FFFFFFF);
    chk("ovf addi flag", {31'd0, overflow}, 32'd1);
    run_alu("ovf ctrl00", 2'd0, 6'd0, 6'b100000, 5'd0, 32'h7FFFFFFF, 32'h1, 32'h80000000);
    chk("ovf ctrl00 flag", {31'd0, overflow}, 32'd0);
`endif

    for (int n = 0; n < 300; n++) begin
      logic [1:0]  c;
      logic [5:0]  o, f;
      logic [4:0]  sa, rtf;
      logic [31:0] a, b, rs, rt;
      logic [5:0]  fl[16];
      logic [5:0]  ol[14];
      fl = '{6'd32, 6'd33, 6'd34, 6'd35, 6'd36, 6'd37, 6'd38, 6'd39,
             6'd42, 6'd43, 6'd0, 6'd2, 6'd3, 6'd4, 6'd6, 6'd7};
      ol = '{6'd8, 6'd9, 6'd12, 6'd13, 6'd14, 6'd10, 6'd11, 6'd15,
             6'd4, 6'd5, 6'd6, 6'd7, 6'd1, 6'd0};
      c   = 2'($urandom_range(0, 3));
      f   = ($urandom_range(0, 7) == 0) ? 6'($urandom) : fl[$urandom_range(0, 15)];
      o   = ($urandom_range(0, 7) == 0) ? 6'($urandom) : ol[$urandom_range(0, 13)];
      sa  = 5'($urandom);
      rtf = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 1));
      a   = ($urandom_range(0, 5) == 0) ? 32'h7FFFFFFF : $urandom;
      b   = ($urandom_range(0, 5) == 0) ? 32'h80000000 : $urandom;
      rs  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      rt  = ($urandom_range(0, 3) == 0) ? rs : $urandom;
      rt_field = rtf; rs_data = rs; rt_data = rt;
      run_alu($sformatf("rnd%0d", n), c, o, f, sa, a, b, ref_alu(c, o, f, sa, a, b));
      chk($sformatf("rnd%0d branch", n), {31'd0, branch_taken}, {31'd0, ref_branch(o, rtf, rs, rt)});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
